// File: rtl/gcd_stein.sv
// gcd_stein: binary (Stein) GCD engine, one reduction step per clock, start/ready in, valid/ack out.
// Defining GCD_STEIN_CYCCNT_EN adds a `cycles` output holding the LOOP-cycle count of the last pair.
module gcd_stein #(
  parameter int WIDTH = 16,
  parameter int FW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] m_in,
  input  logic [WIDTH-1:0] n_in,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  input  logic             ack,
  output logic [WIDTH-1:0] gcd
`ifdef GCD_STEIN_CYCCNT_EN
  ,
  output logic [$clog2(3*WIDTH+3)-1:0] cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_n;
  logic [FW-1:0]    r_factor;
  logic [WIDTH-1:0] r_gcd;
  logic             w_accept;
  logic             w_zero;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_zero   = (r_m == '0) || (r_n == '0);
  assign gcd      = r_gcd;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    valid        = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_state_next = S_LOOP;
      end
      S_LOOP: begin
        busy = 1'b1;
        if (w_zero) w_state_next = S_DONE;
      end
      S_DONE: begin
        valid = 1'b1;
        if (ack) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m      <= '0;
      r_n      <= '0;
      r_factor <= '0;
      r_gcd    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_m      <= m_in;
            r_n      <= n_in;
            r_factor <= '0;
          end
        end
        S_LOOP: begin
          // One operand zero means the other (times the shared power of two) is the answer.
          if (w_zero) begin
            r_gcd <= (r_m | r_n) << r_factor;
          end else if (!r_m[0] && !r_n[0]) begin
            r_m      <= r_m >> 1;
            r_n      <= r_n >> 1;
            r_factor <= r_factor + FW'(1);
          end else if (!r_m[0]) begin
            r_m <= r_m >> 1;
          end else if (!r_n[0]) begin
            r_n <= r_n >> 1;
          end else if (r_m >= r_n) begin
            r_m <= r_m - r_n;
          end else begin
            r_n <= r_n - r_m;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_STEIN_CYCCNT_EN
  localparam int CW = $clog2(3*WIDTH+3);
  logic [CW-1:0] r_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_cycles <= '0;
    else if (w_accept)           r_cycles <= '0;
    else if (r_state == S_LOOP)  r_cycles <= r_cycles + CW'(1);
  end

  assign cycles = r_cycles;
`endif

endmodule

// File: tb/tb_gcd_stein.sv
// tb_gcd_stein: random and directed checks of gcd_stein at WIDTH=16 and WIDTH=8 against an
// arithmetic reference (Euclid for the result, reduction-rule step count for latency).
module tb_gcd_stein;

  localparam int W16 = 16;
  localparam int W8  = 8;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic           start16 = 1'b0, ack16 = 1'b0;
  logic [W16-1:0] m16 = '0, n16 = '0, gcd16;
  logic           ready16, busy16, valid16;
  logic [W16-1:0] last16 = '0;

  logic           start8 = 1'b0, ack8 = 1'b0;
  logic [W8-1:0]  m8 = '0, n8 = '0, gcd8;
  logic           ready8, busy8, valid8;
  logic [W8-1:0]  last8 = '0;

`ifdef GCD_STEIN_CYCCNT_EN
  logic [$clog2(3*W16+3)-1:0] cycles16;
  logic [$clog2(3*W8+3)-1:0]  cycles8;
`endif

  always #5 clk = ~clk;

  gcd_stein #(.WIDTH(W16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .m_in(m16), .n_in(n16),
    .ready(ready16), .busy(busy16), .valid(valid16), .ack(ack16), .gcd(gcd16)
`ifdef GCD_STEIN_CYCCNT_EN
    , .cycles(cycles16)
`endif
  );

  gcd_stein #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .m_in(m8), .n_in(n8),
    .ready(ready8), .busy(busy8), .valid(valid8), .ack(ack8), .gcd(gcd8)
`ifdef GCD_STEIN_CYCCNT_EN
    , .cycles(cycles8)
`endif
  );

  function automatic longint ref_gcd(longint a, longint b);
    longint t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Cycles spent in LOOP: one per reduction applied, plus the final zero-detect cycle.
  function automatic int ref_lat(longint a, longint b);
    int steps;
    steps = 1;
    while (a != 0 && b != 0) begin
      if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a >= b)     a = a - b;
      else                 b = b - a;
      steps++;
    end
    return steps;
  endfunction

  // Called with the bench at #1 after an edge and dut16 idle.
  task automatic run16(input logic [W16-1:0] m, input logic [W16-1:0] n, input string tag,
                       output int lat);
    logic [W16-1:0] exp_g;
    int             exp_l;
    exp_g = W16'(ref_gcd(m, n));
    exp_l = ref_lat(m, n);
    checks++;
    if (ready16 !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_start: got %b want 1", tag, ready16);
    end
    start16 = 1'b1; m16 = m; n16 = n;
    @(posedge clk); #1;
    start16 = 1'b0;
    checks++;
    if (busy16 !== 1'b1 || gcd16 !== last16) begin
      failures++;
      $display("FAIL %s loop_entry: busy=%b gcd=%0d want busy=1 gcd=%0d", tag, busy16, gcd16, last16);
    end
    lat = 0;
    while (valid16 !== 1'b1 && lat < 3*W16+10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (valid16 !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout: valid=%b after %0d cycles want 1", tag, valid16, lat);
    end else begin
      checks++;
      if (gcd16 !== exp_g) begin
        failures++;
        $display("FAIL %s gcd(%0d,%0d): got %0d want %0d", tag, m, n, gcd16, exp_g);
      end
      checks++;
      if (lat != exp_l) begin
        failures++;
        $display("FAIL %s latency(%0d,%0d): got %0d want %0d", tag, m, n, lat, exp_l);
      end
`ifdef GCD_STEIN_CYCCNT_EN
      checks++;
      if (int'(cycles16) != exp_l) begin
        failures++;
        $display("FAIL %s cycles: got %0d want %0d", tag, cycles16, exp_l);
      end
`endif
    end
    last16 = exp_g;
    ack16 = 1'b1;
    @(posedge clk); #1;
    ack16 = 1'b0;
    checks++;
    if (ready16 !== 1'b1 || valid16 !== 1'b0 || gcd16 !== exp_g) begin
      failures++;
      $display("FAIL %s after_ack: ready=%b valid=%b gcd=%0d want 1 0 %0d", tag, ready16, valid16, gcd16, exp_g);
    end
  endtask

  task automatic run8(input logic [W8-1:0] m, input logic [W8-1:0] n, input string tag,
                      output int lat);
    logic [W8-1:0] exp_g;
    int            exp_l;
    exp_g = W8'(ref_gcd(m, n));
    exp_l = ref_lat(m, n);
    start8 = 1'b1; m8 = m; n8 = n;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || gcd8 !== last8) begin
      failures++;
      $display("FAIL %s loop_entry: busy=%b gcd=%0d want busy=1 gcd=%0d", tag, busy8, gcd8, last8);
    end
    lat = 0;
    while (valid8 !== 1'b1 && lat < 3*W8+10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (valid8 !== 1'b1 || gcd8 !== exp_g || lat != exp_l || lat > 3*W8+2) begin
      failures++;
      $display("FAIL %s gcd8(%0d,%0d): valid=%b gcd=%0d lat=%0d want gcd=%0d lat=%0d", tag, m, n,
               valid8, gcd8, lat, exp_g, exp_l);
    end
`ifdef GCD_STEIN_CYCCNT_EN
    checks++;
    if (int'(cycles8) != exp_l) begin
      failures++;
      $display("FAIL %s cycles8: got %0d want %0d", tag, cycles8, exp_l);
    end
`endif
    last8 = exp_g;
    ack8 = 1'b1;
    @(posedge clk); #1;
    ack8 = 1'b0;
    checks++;
    if (ready8 !== 1'b1 || valid8 !== 1'b0) begin
      failures++;
      $display("FAIL %s after_ack8: ready=%b valid=%b want 1 0", tag, ready8, valid8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready16 !== 1'b1 || busy16 !== 1'b0 || valid16 !== 1'b0 || gcd16 !== '0 ||
        ready8 !== 1'b1 || busy8 !== 1'b0 || valid8 !== 1'b0 || gcd8 !== '0) begin
      failures++;
      $display("FAIL reset_values: r16=%b b16=%b v16=%b g16=%0d r8=%b b8=%b v8=%b g8=%0d want 1 0 0 0",
               ready16, busy16, valid16, gcd16, ready8, busy8, valid8, gcd8);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    run16(16'd12, 16'd8, "basic_12_8", lat);
    checks++;
    if (lat != 7 || last16 !== 16'd4) begin
      failures++;
      $display("FAIL basic_example: lat=%0d gcd=%0d want 7 and 4", lat, last16);
    end
  endtask

  task automatic test_zero();
    int lat;
    ack16 = 1'b1;
    @(posedge clk); #1;
    ack16 = 1'b0;
    checks++;
    if (ready16 !== 1'b1 || valid16 !== 1'b0) begin
      failures++;
      $display("FAIL ack_in_idle: ready=%b valid=%b want 1 0", ready16, valid16);
    end
    run16(16'd0, 16'd0, "zero_0_0", lat);
    run16(16'd0, 16'd35, "zero_0_35", lat);
    run16(16'd40, 16'd0, "zero_40_0", lat);
  endtask

  task automatic test_backpressure();
    int lat;
    run16(16'd9, 16'd3, "pre_bp", lat);
    start16 = 1'b1; m16 = 16'd2322; n16 = 16'd654;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (valid16 !== 1'b1 && lat < 3*W16+10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (valid16 !== 1'b1 || gcd16 !== 16'd6 || lat != ref_lat(2322, 654)) begin
      failures++;
      $display("FAIL bp_result: valid=%b gcd=%0d lat=%0d want 1 6 %0d", valid16, gcd16, lat,
               ref_lat(2322, 654));
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin start16 = 1'b1; m16 = 16'd100; n16 = 16'd75; end
      if (i == 6) start16 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (valid16 !== 1'b1 || gcd16 !== 16'd6 || ready16 !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b gcd=%0d ready=%b want 1 6 0", i, valid16, gcd16, ready16);
      end
    end
    ack16 = 1'b1;
    @(posedge clk); #1;
    ack16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready16 !== 1'b1 || busy16 !== 1'b0 || valid16 !== 1'b0 || gcd16 !== 16'd6) begin
      failures++;
      $display("FAIL bp_start_ignored: ready=%b busy=%b valid=%b gcd=%0d want 1 0 0 6",
               ready16, busy16, valid16, gcd16);
    end
    last16 = 16'd6;
  endtask

  task automatic test_abort();
    int lat;
    start16 = 1'b1; m16 = 16'd1000; n16 = 16'd250;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy16 !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy: busy=%b want 1", busy16);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ready16 !== 1'b1 || busy16 !== 1'b0 || valid16 !== 1'b0 || gcd16 !== '0) begin
      failures++;
      $display("FAIL abort_async: ready=%b busy=%b valid=%b gcd=%0d want 1 0 0 0",
               ready16, busy16, valid16, gcd16);
    end
`ifdef GCD_STEIN_CYCCNT_EN
    checks++;
    if (cycles16 !== '0) begin
      failures++;
      $display("FAIL abort_cycles: got %0d want 0", cycles16);
    end
`endif
    last16 = '0;
    last8  = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    run16(16'd9, 16'd6, "after_abort_9_6", lat);
    checks++;
    if (last16 !== 16'd3 || lat != 5) begin
      failures++;
      $display("FAIL after_abort: gcd=%0d lat=%0d want 3 5", gcd16, lat);
    end
  endtask

  task automatic test_random16();
    int             lat;
    int             k;
    logic [W16-1:0] a, b;
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 5);
      a = W16'($urandom) >> k << k;
      b = W16'($urandom) >> k << k;
      if ($urandom_range(0, 15) == 0) a = '0;
      if ($urandom_range(0, 15) == 0) b = '0;
      run16(a, b, "rand16", lat);
    end
  endtask

  task automatic test_width8();
    int           lat;
    int           max_lat;
    logic [W8-1:0] corners [6];
    corners = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd255};
    run8(8'd128, 8'd128, "w8_128_128", lat);
    checks++;
    if (last8 !== 8'd128) begin
      failures++;
      $display("FAIL w8_no_truncation: got %0d want 128", gcd8);
    end
    run8(8'd255, 8'd1, "w8_255_1", lat);
    max_lat = 0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) begin
        run8(corners[i], corners[j], "w8_corner", lat);
        if (lat > max_lat) max_lat = lat;
      end
    for (int i = 0; i < 1200; i++) begin
      run8(W8'($urandom), W8'($urandom), "w8_sweep", lat);
      if (lat > max_lat) max_lat = lat;
    end
    checks++;
    if (max_lat > 3*W8+2) begin
      failures++;
      $display("FAIL w8_latency_bound: max=%0d want <= %0d", max_lat, 3*W8+2);
    end
  endtask

  task automatic test_back_to_back();
    logic [W16-1:0] qm[$];
    logic [W16-1:0] qn[$];
    int   cyc, accepts, results, last_acc, exp_gap;
    logic rdy_before;
    cyc = 0; accepts = 0; results = 0; last_acc = -1; exp_gap = 0;
    ack16 = 1'b1; start16 = 1'b1;
    m16 = W16'($urandom_range(1, 5000)); n16 = W16'($urandom_range(1, 5000));
    while ((results < 6 || accepts < 6) && cyc < 2000) begin
      rdy_before = ready16;
      @(posedge clk); #1;
      cyc++;
      if (rdy_before === 1'b1 && start16 === 1'b1) begin
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != exp_gap) begin
            failures++;
            $display("FAIL b2b_gap: got %0d want %0d", cyc - last_acc, exp_gap);
          end
        end
        exp_gap = ref_lat(m16, n16) + 2;
        qm.push_back(m16); qn.push_back(n16);
        last_acc = cyc;
        accepts++;
        if (accepts == 6) start16 = 1'b0;
        else begin
          m16 = W16'($urandom_range(0, 5000)); n16 = W16'($urandom_range(1, 5000));
        end
      end
      if (valid16 === 1'b1) begin
        results++;
        checks++;
        if (qm.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra_result: got gcd=%0d with no pair outstanding", gcd16);
        end else begin
          if (gcd16 !== W16'(ref_gcd(qm[0], qn[0]))) begin
            failures++;
            $display("FAIL b2b_gcd(%0d,%0d): got %0d want %0d", qm[0], qn[0], gcd16,
                     W16'(ref_gcd(qm[0], qn[0])));
          end
          last16 = W16'(ref_gcd(qm[0], qn[0]));
          void'(qm.pop_front());
          void'(qn.pop_front());
        end
      end
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (valid16 === 1'b1) results++;
    end
    checks++;
    if (accepts != 6 || results != 6) begin
      failures++;
      $display("FAIL b2b_count: accepts=%0d results=%0d want 6 6", accepts, results);
    end
    ack16 = 1'b0; start16 = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_abort();
    test_random16();
    test_width8();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
